// File: rtl/dram_pkg.sv
// Shared constants and types for the DRAM request arbiter.
package dram_pkg;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 128;

    // Worst-case dram_control transaction in cycles: a refresh followed by a write.
    localparam int T_WORST_TXN = 48;

    // Default post-reset quiet window; must stay above T_WORST_TXN so a
    // transaction cut off by reset drains before the first new grant.
    localparam int RST_HOLD_DEF = T_WORST_TXN + 16;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_IDLE = 2'd1,
        S_BUSY = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: picks the first set request bit
// strictly above `last`, wrapping to the lowest set bit when none is above.
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic found_hi;

    // Scan downward so the lowest qualifying index is the one left in idx.
    always_comb begin
        any      = |req;
        idx      = '0;
        found_hi = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (IDX_W'(i) > last)) begin
                idx      = IDX_W'(i);
                found_hi = 1'b1;
            end
        end
        if (!found_hi) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one dram_control request port among NREQ
// requesters. The granted request is registered and frozen for the whole
// DRAM transaction; completion returns a one-cycle ready pulse to the winner.
//
// Handshake: a requester raises req_valid[i] with addr/wmask/wdata and keeps
// it high until req_ready[i] pulses for one cycle; it must then drop valid or
// present a new request. Towards dram_control, mem_valid stays high with
// frozen mem_* until mem_ready, and falls in the cycle after mem_ready.
module dram_arbiter
    import dram_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int RST_HOLD = RST_HOLD_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ-1:0]        req_wmask,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0]      req_rdata,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_wmask,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [1:0]             dbg_state
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [IDX_W-1:0]   gnt;
    logic [IDX_W-1:0]   last;

    logic [NREQ-1:0]    cand;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_wmask;
    logic [DATA_W-1:0]  sel_wdata;

    logic               hold_done;
    logic               load_gnt;
    logic               complete;
    logic [NREQ-1:0]    ready_d;

    // A port is never a candidate in its own ready cycle.
    assign cand      = req_valid & ~req_ready;
    assign dbg_state = state_q;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (cand),
        .last (last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Route the picked port's request fields to the mem_* load path.
    always_comb begin
        sel_addr  = '0;
        sel_wmask = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wmask = req_wmask[i];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; mem_ready only matters while a transaction is in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HOLD:  if (hold_done) state_d = S_IDLE;
            S_IDLE:  if (pick_any)  state_d = S_BUSY;
            S_BUSY:  if (mem_ready) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_HOLD;
        endcase
    end

    // Output strobes decoded from state: grant load, completion, ready vector.
    always_comb begin
        hold_done = (state_q == S_HOLD) && (hold_cnt == HOLD_W'(RST_HOLD - 1));
        load_gnt  = (state_q == S_IDLE) && pick_any;
        complete  = (state_q == S_BUSY) && mem_ready;
        ready_d   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (complete && (gnt == IDX_W'(i))) begin
                ready_d[i] = 1'b1;
            end
        end
    end

    // Post-reset quiet counter; absorbs stale mem_ready from a cut-off transaction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_cnt <= '0;
        end else if (state_q == S_HOLD) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // Registered grant, frozen mem_* request, read data capture and ready pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wmask <= 1'b0;
            mem_wdata <= '0;
            gnt       <= '0;
            last      <= IDX_W'(NREQ - 1);
            req_ready <= '0;
            req_rdata <= '0;
        end else begin
            req_ready <= ready_d;
            if (load_gnt) begin
                mem_valid <= 1'b1;
                mem_addr  <= sel_addr;
                mem_wmask <= sel_wmask;
                mem_wdata <= sel_wdata;
                gnt       <= pick_idx;
            end
            if (complete) begin
                mem_valid <= 1'b0;
                last      <= gnt;
                if (!mem_wmask) begin
                    req_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with two requesters and a hand-driven DRAM side.
module tb_dram_arbiter;

    localparam int NREQ = 2;
    localparam int HOLD = 64;
    localparam int AW   = 29;
    localparam int DW   = 128;

    localparam logic [DW-1:0] RD0   = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [DW-1:0] WR_A  = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [DW-1:0] WR_B  = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;

    logic               clk = 1'b0;
    logic               rstn;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_wmask;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]      req_rdata;
    logic               mem_valid;
    logic               mem_ready;
    logic [AW-1:0]      mem_addr;
    logic               mem_wmask;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic [1:0]         dbg_state;

    int checks = 0;
    int errors = 0;

    dram_arbiter #(
        .NREQ     (NREQ),
        .RST_HOLD (HOLD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wmask (req_wmask),
        .req_wdata (req_wdata),
        .req_rdata (req_rdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    // Clock: 10 time-unit period; DUT acts on posedge, bench on negedge.
    always #5 clk = ~clk;

    // Driver: load one requester's request fields.
    task automatic set_port(input int p, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        req_addr[p*AW +: AW]  = a;
        req_wmask[p]          = w;
        req_wdata[p*DW +: DW] = d;
    endtask

    // Driver: DRAM side raises ready with read data for exactly one cycle.
    task automatic dram_respond(input logic [DW-1:0] d);
        mem_rdata = d;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b exp 0", mem_valid); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h exp 0", mem_addr); end
        checks++; if (mem_wmask !== 1'b0) begin errors++; $display("FAIL reset_mem_wmask: got %b exp 0", mem_wmask); end
        checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %h exp 0", mem_wdata); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b exp 00", req_ready); end
        checks++; if (req_rdata !== '0) begin errors++; $display("FAIL reset_req_rdata: got %h exp 0", req_rdata); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
        rstn = 1'b1;
        bad = 0;
        for (int i = 1; i <= HOLD; i++) begin
            @(negedge clk);
            if (mem_valid !== 1'b0 || req_ready !== 2'b00) bad++;
            if (i == HOLD - 1) begin
                checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL hold_last_cycle_state: got %0d exp 0", dbg_state); end
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_quiet: got %0d active cycles exp 0", bad); end
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL hold_exit_idle: got %0d exp 1", dbg_state); end
    endtask

    task automatic test_single_read();
        int bad;
        set_port(0, 29'h0000400, 1'b0, '0);
        req_valid = 2'b01;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL read_grant_valid: got %b exp 1", mem_valid); end
        checks++; if (mem_addr !== 29'h0000400) begin errors++; $display("FAIL read_grant_addr: got %h exp 0000400", mem_addr); end
        checks++; if (mem_wmask !== 1'b0) begin errors++; $display("FAIL read_grant_wmask: got %b exp 0", mem_wmask); end
        bad = 0;
        repeat (11) begin
            @(negedge clk);
            if (mem_valid !== 1'b1 || req_ready !== 2'b00) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL read_valid_held: got %0d bad cycles exp 0", bad); end
        dram_respond(RD0);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL read_ready_pulse: got %b exp 01", req_ready); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL read_valid_drop: got %b exp 0", mem_valid); end
        checks++; if (req_rdata !== RD0) begin errors++; $display("FAIL read_rdata: got %h exp %h", req_rdata, RD0); end
        req_valid = 2'b00;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL read_ready_one_cycle: got %b exp 00", req_ready); end
        @(negedge clk);
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL read_no_regrant: got %b exp 0", mem_valid); end
    endtask

    task automatic test_write_freeze();
        int bad;
        logic [DW-1:0] model_wdata;
        set_port(1, 29'h0001234, 1'b1, WR_A);
        req_valid = 2'b10;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b1 || mem_wmask !== 1'b1) begin errors++; $display("FAIL write_grant: got valid %b wmask %b exp 1 1", mem_valid, mem_wmask); end
        checks++; if (mem_wdata !== WR_A) begin errors++; $display("FAIL write_grant_wdata: got %h exp %h", mem_wdata, WR_A); end
        set_port(1, 29'h0000777, 1'b1, WR_B);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_wdata !== WR_A || mem_addr !== 29'h0001234 || mem_valid !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL write_frozen: got %0d bad cycles exp 0", bad); end
        model_wdata = mem_wdata;
        dram_respond(128'hDEAD);
        checks++; if (model_wdata !== WR_A) begin errors++; $display("FAIL write_model_data: got %h exp %h", model_wdata, WR_A); end
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL write_ready_pulse: got %b exp 10", req_ready); end
        checks++; if (req_rdata !== RD0) begin errors++; $display("FAIL write_keeps_rdata: got %h exp %h", req_rdata, RD0); end
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention();
        int exp_p;
        logic [AW-1:0] exp_addr;
        logic [NREQ-1:0] exp_rdy;
        logic [DW-1:0] rd;
        set_port(0, 29'h0000010, 1'b0, '0);
        set_port(1, 29'h0000020, 1'b0, '0);
        req_valid = 2'b11;
        @(negedge clk);
        for (int t = 0; t < 4; t++) begin
            exp_p    = t % 2;
            exp_addr = (exp_p == 1) ? 29'h0000020 : 29'h0000010;
            exp_rdy  = (exp_p == 1) ? 2'b10 : 2'b01;
            rd       = {96'h0, 32'hC0DE_0000 + 32'(t)};
            checks++; if (mem_valid !== 1'b1 || mem_addr !== exp_addr) begin errors++; $display("FAIL contention_grant%0d: got valid %b addr %h exp 1 %h", t, mem_valid, mem_addr, exp_addr); end
            repeat (2) @(negedge clk);
            dram_respond(rd);
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL contention_ready%0d: got %b exp %b", t, req_ready, exp_rdy); end
            checks++; if (mem_valid !== 1'b0 || req_rdata !== rd) begin errors++; $display("FAIL contention_done%0d: got valid %b rdata %h exp 0 %h", t, mem_valid, req_rdata, rd); end
            if (t == 3) req_valid = 2'b00;
            @(negedge clk);
            checks++; if (mem_valid !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL contention_idle%0d: got valid %b ready %b exp 0 00", t, mem_valid, req_ready); end
            @(negedge clk);
        end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL contention_drained: got %b exp 0", mem_valid); end
    endtask

    task automatic test_withdrawal();
        int bad;
        set_port(1, 29'h0000055, 1'b0, '0);
        req_valid = 2'b10;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 29'h0000055) begin errors++; $display("FAIL withdraw_p1_grant: got valid %b addr %h exp 1 0000055", mem_valid, mem_addr); end
        set_port(0, 29'h0000066, 1'b0, '0);
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        req_valid = 2'b10;
        @(negedge clk);
        dram_respond(128'h5555);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL withdraw_p1_ready: got %b exp 10", req_ready); end
        req_valid = 2'b00;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_valid !== 1'b0 || req_ready !== 2'b00) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL withdraw_no_grant: got %0d bad cycles exp 0", bad); end
    endtask

    task automatic test_same_port_repeat();
        set_port(0, 29'h0000100, 1'b0, '0);
        req_valid = 2'b01;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 29'h0000100) begin errors++; $display("FAIL repeat_first_grant: got valid %b addr %h exp 1 0000100", mem_valid, mem_addr); end
        @(negedge clk);
        dram_respond(128'h1111);
        checks++; if (req_ready !== 2'b01 || mem_valid !== 1'b0) begin errors++; $display("FAIL repeat_pulse_cycle: got ready %b valid %b exp 01 0", req_ready, mem_valid); end
        checks++; if (dbg_state !== 2'd3) begin errors++; $display("FAIL repeat_done_state: got %0d exp 3", dbg_state); end
        set_port(0, 29'h0000104, 1'b0, '0);
        @(negedge clk);
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL repeat_idle_cycle: got %b exp 0", mem_valid); end
        @(negedge clk);
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 29'h0000104) begin errors++; $display("FAIL repeat_regrant: got valid %b addr %h exp 1 0000104", mem_valid, mem_addr); end
        @(negedge clk);
        dram_respond(128'h2222);
        checks++; if (req_ready !== 2'b01 || req_rdata !== 128'h2222) begin errors++; $display("FAIL repeat_second_done: got ready %b rdata %h exp 01 2222", req_ready, req_rdata); end
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int bad;
        set_port(1, 29'h0001ABC, 1'b1, WR_A);
        req_valid = 2'b10;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b1 || mem_wmask !== 1'b1) begin errors++; $display("FAIL midrst_grant: got valid %b wmask %b exp 1 1", mem_valid, mem_wmask); end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0 || mem_addr !== '0 || mem_wmask !== 1'b0 || mem_wdata !== '0) begin errors++; $display("FAIL midrst_mem_async: got %b %h %b %h exp all 0", mem_valid, mem_addr, mem_wmask, mem_wdata); end
        checks++; if (req_ready !== 2'b00 || req_rdata !== '0) begin errors++; $display("FAIL midrst_req_async: got %b %h exp 00 0", req_ready, req_rdata); end
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        set_port(0, 29'h0002000, 1'b0, '0);
        req_valid = 2'b01;
        rstn = 1'b1;
        bad = 0;
        for (int i = 1; i <= HOLD; i++) begin
            @(negedge clk);
            if (mem_valid !== 1'b0 || req_ready !== 2'b00) bad++;
            if (i == 5) mem_ready = 1'b1;
            if (i == 6) mem_ready = 1'b0;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_hold_quiet: got %0d bad cycles exp 0", bad); end
        @(negedge clk);
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 29'h0002000) begin errors++; $display("FAIL midrst_first_grant: got valid %b addr %h exp 1 0002000", mem_valid, mem_addr); end
        checks++; if (mem_wmask !== 1'b0) begin errors++; $display("FAIL midrst_grant_wmask: got %b exp 0", mem_wmask); end
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_wmask = '0;
        req_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        test_reset();
        test_single_read();
        test_write_freeze();
        test_contention();
        test_withdrawal();
        test_same_port_repeat();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
